operand_streamer: RTL and testbench

Parametrised stimulus streamer that feeds a batch of NUM operand tuples from a host-loaded payload buffer into a DUT over a valid/ready handshake, one tuple per accepted beat. It then captures the DUT result a fixed LAT cycles later and keeps a running checksum. Supports one-shot and continuous-loop modes and flags each completed batch on a toggling `xmit_en_o`. It sits between the host/testbench payload array and the BFM-wrapped DUT, and generalises the earlier fixed two-operand streamer.

---
 rtl/operand_streamer_pkg.sv | 14 +
 rtl/operand_streamer_res_capture.sv | 48 ++++
 rtl/operand_streamer.sv | 125 ++++++++++++
 tb/tb_operand_streamer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_streamer_pkg.sv
// Shared types and helpers for the operand streamer: FSM state encoding,
// checksum width and flat-buffer tuple addressing.
package streamer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int CHECKSUM_W = 32;

  // Bit offset of tuple n inside the flat payload buffer.
  function automatic int tuple_lsb(int n, int num_ops, int item_w);
    return n * num_ops * item_w;
  endfunction

endpackage

// File: rtl/operand_streamer_res_capture.sv
// Result capture: delays accepted-beat tags by LAT cycles and folds the DUT
// result into last value, running checksum and result count.
module res_capture
  import streamer_pkg::*;
#(
  parameter int LAT       = 1,
  parameter int RES_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [RES_WIDTH-1:0]  res_i,
  output logic [RES_WIDTH-1:0]  last_res_o,
  output logic [CHECKSUM_W-1:0] checksum_o,
  output logic [CHECKSUM_W-1:0] res_count_o
);

  logic [LAT-1:0] tag_p0;
  logic [LAT-1:0] tag_nxt;

  if (LAT == 1) begin : g_lat1
    assign tag_nxt = accept_i;
  end else begin : g_latn
    assign tag_nxt = {tag_p0[LAT-2:0], accept_i};
  end

  // Tag stage boundary: the oldest tag marks the cycle res_i is valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_p0      <= '0;
      last_res_o  <= '0;
      checksum_o  <= '0;
      res_count_o <= '0;
    end else begin
      tag_p0 <= tag_nxt;
      if (clear_i) begin
        checksum_o  <= '0;
        res_count_o <= '0;
      end else if (tag_p0[LAT-1]) begin
        last_res_o  <= res_i;
        checksum_o  <= checksum_o + CHECKSUM_W'(res_i);
        res_count_o <= res_count_o + CHECKSUM_W'(1);
      end
    end
  end

endmodule

// File: rtl/operand_streamer.sv
// Streams NUM operand tuples from a host payload buffer to a DUT over
// valid/ready, then drains LAT cycles of results into the capture block.
module operand_streamer
  import streamer_pkg::*;
#(
  parameter int NUM        = 200,
  parameter int NUM_OPS    = 2,
  parameter int ITEM_WIDTH = 8,
  parameter int RES_WIDTH  = 8,
  parameter int LAT        = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM*NUM_OPS*ITEM_WIDTH-1:0] payload_data_i,
  input  logic                             tvalid_i,
  input  logic                             start_i,
  input  logic                             loop_i,
  output logic                             ops_valid_o,
  input  logic                             ops_ready_i,
  output logic [NUM_OPS*ITEM_WIDTH-1:0]    ops_o,
  input  logic [RES_WIDTH-1:0]             res_i,
  output logic [RES_WIDTH-1:0]             last_res_o,
  output logic [CHECKSUM_W-1:0]            checksum_o,
  output logic [CHECKSUM_W-1:0]            res_count_o,
  output logic                             busy_o,
  output logic                             batch_done_o,
  output logic                             xmit_en_o
);

  localparam int IDX_W   = $clog2(NUM);
  localparam int TUPLE_W = NUM_OPS * ITEM_WIDTH;
  localparam int DRAIN_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LAT - 1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [TUPLE_W-1:0]   tuple_arr [NUM];
  logic                 start_ok;
  logic                 accept;

  for (genvar n = 0; n < NUM; n++) begin : g_tuple
    assign tuple_arr[n] = payload_data_i[tuple_lsb(n, NUM_OPS, ITEM_WIDTH) +: TUPLE_W];
  end

  assign idx_nxt  = idx + IDX_W'(1);
  assign start_ok = (state == IDLE || state == DONE) && start_i && tvalid_i;
  assign accept   = ops_valid_o && ops_ready_i;

  // Presentation stage boundary: ops_o/ops_valid_o are registered here.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      idx          <= '0;
      drain_cnt    <= '0;
      ops_valid_o  <= 1'b0;
      ops_o        <= '0;
      busy_o       <= 1'b0;
      batch_done_o <= 1'b0;
      xmit_en_o    <= 1'b1;
    end else begin
      batch_done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state       <= RUN;
            idx         <= '0;
            ops_valid_o <= 1'b1;
            ops_o       <= tuple_arr[0];
            busy_o      <= 1'b1;
          end
        end
        RUN: begin
          // After a loop restart valid is low for one cycle while tuple 0 reloads.
          if (!ops_valid_o) begin
            ops_valid_o <= 1'b1;
            ops_o       <= tuple_arr[idx];
          end else if (ops_ready_i) begin
            if (idx == LAST_IDX) begin
              state       <= DRAIN;
              drain_cnt   <= '0;
              ops_valid_o <= 1'b0;
            end else begin
              idx   <= idx_nxt;
              ops_o <= tuple_arr[idx_nxt];
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            batch_done_o <= 1'b1;
            xmit_en_o    <= ~xmit_en_o;
            if (loop_i) begin
              state <= RUN;
              idx   <= '0;
            end else begin
              state  <= DONE;
              busy_o <= 1'b0;
            end
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  res_capture #(
    .LAT       (LAT),
    .RES_WIDTH (RES_WIDTH)
  ) u_res_capture (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (start_ok),
    .accept_i    (accept),
    .res_i       (res_i),
    .last_res_o  (last_res_o),
    .checksum_o  (checksum_o),
    .res_count_o (res_count_o)
  );

endmodule

// File: tb/tb_operand_streamer.sv
// Bench for operand_streamer: directed scenarios plus random traffic, checked
// every cycle against an event-time reference model of the streamer.
module tb_operand_streamer;

  localparam int NUM        = 4;
  localparam int NUM_OPS    = 2;
  localparam int ITEM_WIDTH = 8;
  localparam int RES_WIDTH  = 8;
  localparam int LAT        = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i     = 1'b1;
  logic        tvalid_i    = 1'b0;
  logic        start_i     = 1'b0;
  logic        loop_i      = 1'b0;
  logic        ops_ready_i = 1'b0;
  logic [15:0] pay [NUM];
  logic [NUM*NUM_OPS*ITEM_WIDTH-1:0] payload;
  logic [7:0]  res_i = '0;

  logic        ops_valid_o;
  logic [15:0] ops_o;
  logic [7:0]  last_res_o;
  logic [31:0] checksum_o;
  logic [31:0] res_count_o;
  logic        busy_o;
  logic        batch_done_o;
  logic        xmit_en_o;

  assign payload = {pay[3], pay[2], pay[1], pay[0]};

  operand_streamer #(
    .NUM(NUM), .NUM_OPS(NUM_OPS), .ITEM_WIDTH(ITEM_WIDTH),
    .RES_WIDTH(RES_WIDTH), .LAT(LAT)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .payload_data_i (payload),
    .tvalid_i       (tvalid_i),
    .start_i        (start_i),
    .loop_i         (loop_i),
    .ops_valid_o    (ops_valid_o),
    .ops_ready_i    (ops_ready_i),
    .ops_o          (ops_o),
    .res_i          (res_i),
    .last_res_o     (last_res_o),
    .checksum_o     (checksum_o),
    .res_count_o    (res_count_o),
    .busy_o         (busy_o),
    .batch_done_o   (batch_done_o),
    .xmit_en_o      (xmit_en_o)
  );

  // DUT stand-in: registered 8-bit sum of the two operands.
  always @(posedge clk)
    if (ops_valid_o && ops_ready_i) res_i <= ops_o[7:0] + ops_o[15:8];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] res_of(input int i);
    return pay[i][7:0] + pay[i][15:8];
  endfunction

  // Reference model: timestamps of batch events, a queue of pending results.
  typedef struct { int due; logic [7:0] v; } pend_t;
  pend_t       pend [$];
  pend_t       p;
  int          cyc = 0;
  int          m_idx = 0, m_end_at = -1, m_restart_at = -1;
  logic        armed = 1'b0;
  logic        m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_xmit = 1'b1, acc;
  logic [15:0] m_ops = '0;
  logic [7:0]  m_last = '0;
  logic [31:0] m_cs = '0, m_cnt = '0;

  always @(negedge clk) begin
    if (armed) begin
      chk("ops_valid",  32'(ops_valid_o),  32'(m_valid));
      chk("ops",        32'(ops_o),        32'(m_ops));
      chk("last_res",   32'(last_res_o),   32'(m_last));
      chk("checksum",   checksum_o,        m_cs);
      chk("res_count",  res_count_o,       m_cnt);
      chk("busy",       32'(busy_o),       32'(m_busy));
      chk("batch_done", 32'(batch_done_o), 32'(m_done));
      chk("xmit_en",    32'(xmit_en_o),    32'(m_xmit));
    end
    if (reset_i) begin
      m_valid = 0; m_ops = '0; m_idx = 0; m_busy = 0; m_done = 0; m_xmit = 1;
      m_cs = '0; m_cnt = '0; m_last = '0; pend.delete();
      m_end_at = -1; m_restart_at = -1;
      armed = 1'b1;
    end else begin
      acc = m_valid && ops_ready_i;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        m_last = p.v; m_cs = m_cs + 32'(p.v); m_cnt = m_cnt + 1;
      end
      if (acc) pend.push_back('{due: cyc + LAT, v: res_of(m_idx)});
      m_done = (m_end_at == cyc);
      if (!m_busy) begin
        if (start_i && tvalid_i) begin
          m_busy = 1; m_valid = 1; m_idx = 0; m_ops = pay[0]; m_cs = '0; m_cnt = '0;
        end
      end else begin
        if (acc) begin
          if (m_idx == NUM - 1) begin
            m_valid = 0; m_end_at = cyc + LAT;
          end else begin
            m_idx++; m_ops = pay[m_idx];
          end
        end
        if (m_end_at == cyc) begin
          m_xmit = !m_xmit; m_end_at = -1;
          if (loop_i) begin m_idx = 0; m_restart_at = cyc + 1; end
          else m_busy = 0;
        end else if (m_restart_at == cyc) begin
          m_valid = 1; m_ops = pay[0]; m_restart_at = -1;
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch();
    start_i = 1; tvalid_i = 1;
    step();
    start_i = 0;
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    do begin step(); n++; end while (!batch_done_o && n < 60);
    chk("batch_done_seen", 32'(batch_done_o), 32'd1);
  endtask

  logic xb;

  initial begin
    pay[0] = 16'h0201; pay[1] = 16'h0403; pay[2] = 16'h0605; pay[3] = 16'h0807;
    repeat (3) step();
    reset_i = 0;
    chk("rst_xmit", 32'(xmit_en_o), 32'd1);
    chk("rst_cs", checksum_o, 32'd0);

    // 1: single batch, full throughput
    ops_ready_i = 1; loop_i = 0;
    start_batch();
    chk("t1_tuple0", 32'(ops_o), 32'h0201); step();
    chk("t1_tuple1", 32'(ops_o), 32'h0403); step();
    chk("t1_tuple2", 32'(ops_o), 32'h0605); step();
    chk("t1_tuple3", 32'(ops_o), 32'h0807); step();
    chk("t1_no_pulse_c5", 32'(batch_done_o), 32'd0); step();
    chk("t1_pulse_c6", 32'(batch_done_o), 32'd1);
    chk("t1_cs", checksum_o, 32'd36);
    chk("t1_cnt", res_count_o, 32'd4);
    chk("t1_last", 32'(last_res_o), 32'd15);
    chk("t1_xmit", 32'(xmit_en_o), 32'd0);
    step();
    chk("t1_done_idle", 32'(busy_o), 32'd0);

    // 2: backpressure on tuple 1
    start_batch();
    step();
    ops_ready_i = 0;
    repeat (3) begin
      chk("t2_hold", 32'(ops_o), 32'h0403);
      step();
    end
    ops_ready_i = 1;
    wait_pulse();
    chk("t2_cs", checksum_o, 32'd36);
    chk("t2_cnt", res_count_o, 32'd4);

    // 3: loop mode for three batches
    step();
    xb = xmit_en_o;
    loop_i = 1;
    start_batch();
    wait_pulse();
    chk("t3_gap", 32'(ops_valid_o), 32'd0);
    step();
    chk("t3_repr", 32'(ops_o), 32'h0201);
    wait_pulse();
    loop_i = 0;
    wait_pulse();
    chk("t3_cnt", res_count_o, 32'd12);
    chk("t3_cs", checksum_o, 32'd108);
    chk("t3_xmit", 32'(xmit_en_o), 32'(!xb));
    step();

    // 4: reset after second acceptance
    start_batch();
    step();
    step();
    reset_i = 1;
    step();
    reset_i = 0;
    chk("t4_busy", 32'(busy_o), 32'd0);
    chk("t4_cs", checksum_o, 32'd0);
    chk("t4_ops", 32'(ops_o), 32'd0);
    chk("t4_xmit", 32'(xmit_en_o), 32'd1);
    start_batch();
    wait_pulse();
    chk("t4_cs2", checksum_o, 32'd36);
    step();

    // 5: ignored starts, tvalid drop mid-batch
    start_i = 1; tvalid_i = 0;
    step();
    start_i = 0;
    chk("t5_idle", 32'(busy_o), 32'd0);
    chk("t5_noclr", res_count_o, 32'd4);
    start_batch();
    step();
    start_i = 1; tvalid_i = 0;
    step();
    start_i = 0;
    chk("t5_tuple2", 32'(ops_o), 32'h0605);
    wait_pulse();
    chk("t5_cnt", res_count_o, 32'd4);
    tvalid_i = 1;
    step();

    // 6: restart from DONE with saturating payload
    for (int k = 0; k < NUM; k++) pay[k] = 16'hFFFF;
    start_batch();
    wait_pulse();
    chk("t6_cs", checksum_o, 32'd1016);
    chk("t6_last", 32'(last_res_o), 32'hFE);
    step();

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      reset_i     = ($urandom_range(0, 199) == 0);
      start_i     = ($urandom_range(0, 5) == 0);
      tvalid_i    = ($urandom_range(0, 3) != 0);
      loop_i      = ($urandom_range(0, 2) == 0);
      ops_ready_i = ($urandom_range(0, 3) != 0);
      if (!busy_o && $urandom_range(0, 3) == 0)
        for (int k = 0; k < NUM; k++) pay[k] = 16'($urandom);
      step();
    end
    reset_i = 0; start_i = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
